// File: rtl/uart_led_top.sv
// uart_led_top: 8N1 UART receiver that latches framed bytes onto leds; a btn1 press
// re-transmits the displayed byte on uart_tx.
`timescale 1ns/1ps
module uart_led_top #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rx,
   input  logic       btn1,
   output logic       uart_tx,
   output logic [7:0] leds
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t rx_state, rx_next, tx_state, tx_next;
   logic rx_meta, rx_s, btn_meta, btn_s, btn_d, btn_fall;
   logic [CW-1:0] rx_cnt, tx_cnt;
   logic [2:0] rx_bit, tx_bit;
   logic [7:0] rx_sh, tx_sh;
   logic rx_half, rx_end, tx_end;
   logic rx_shift, rx_load, tx_shift, tx_load;

   // Synchronisers reset to the idle-high level so reset release never looks like an edge.
   always_ff @(posedge clk or posedge reset)
      if (reset) {rx_meta, rx_s, btn_meta, btn_s, btn_d} <= '1;
      else {rx_meta, rx_s, btn_meta, btn_s, btn_d} <= {uart_rx, rx_meta, btn1, btn_meta, btn_s};

   assign btn_fall = btn_d & ~btn_s;
   assign rx_half  = rx_cnt == CW'(CLKS_PER_BIT / 2 - 1);
   assign rx_end   = rx_cnt == CW'(CLKS_PER_BIT - 1);
   assign tx_end   = tx_cnt == CW'(CLKS_PER_BIT - 1);

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rx_state <= IDLE;
         tx_state <= IDLE;
      end else begin
         rx_state <= rx_next;
         tx_state <= tx_next;
      end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         IDLE:    if (!rx_s) rx_next = START;
         START:   if (rx_half) rx_next = rx_s ? IDLE : DATA;
         DATA:    if (rx_end && rx_bit == 3'd7) rx_next = STOP;
         default: if (rx_end) rx_next = IDLE;
      endcase
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         IDLE:    if (btn_fall) tx_next = START;
         START:   if (tx_end) tx_next = DATA;
         DATA:    if (tx_end && tx_bit == 3'd7) tx_next = STOP;
         default: if (tx_end) tx_next = IDLE;
      endcase
   end

   always_comb begin
      rx_shift = rx_state == DATA && rx_end;
      rx_load  = rx_state == STOP && rx_end && rx_s;
      tx_load  = tx_state == IDLE && btn_fall;
      tx_shift = tx_state == DATA && tx_end;
      uart_tx  = tx_state == START ? 1'b0 : tx_state == DATA ? tx_sh[0] : 1'b1;
   end

   // Bit timer restarts on every state change so the first data sample lands one bit after mid-start.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rx_cnt <= '0;
         rx_bit <= '0;
         rx_sh  <= '0;
         leds   <= '0;
      end else begin
         rx_cnt <= (rx_state == IDLE || rx_next != rx_state || rx_end) ? '0 : rx_cnt + 1'b1;
         rx_bit <= rx_state == IDLE ? 3'd0 : rx_shift ? rx_bit + 3'd1 : rx_bit;
         if (rx_shift) rx_sh <= {rx_s, rx_sh[7:1]};
         if (rx_load) leds <= rx_sh;
      end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         tx_cnt <= '0;
         tx_bit <= '0;
         tx_sh  <= '0;
      end else begin
         tx_cnt <= (tx_state == IDLE || tx_end) ? '0 : tx_cnt + 1'b1;
         tx_bit <= tx_state == IDLE ? 3'd0 : tx_shift ? tx_bit + 3'd1 : tx_bit;
         tx_sh  <= tx_load ? leds : tx_shift ? {1'b0, tx_sh[7:1]} : tx_sh;
      end
endmodule

// File: tb/tb_uart_led_top.sv
// tb_uart_led_top: table-driven RX frames with a queue of expected leds values,
// plus hand-written glitch, concurrent RX/TX and reset-mid-frame sequences.
`timescale 1ns/1ps
module tb_uart_led_top;
   localparam int CPB = 8;
   logic clk = 1'b0, reset = 1'b1, uart_rx = 1'b1, btn1 = 1'b1;
   logic uart_tx;
   logic [7:0] leds;
   int n_checks = 0, n_fail = 0, bad = 0, t = 0;
   logic [7:0] cur_leds = 8'h00, tx_byte = 8'h00;
   logic [7:0] rx_q[$];
   logic tx_q[$];
   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic [7:0] exp;
      int         gap;
   } vec_t;
   vec_t vecs[6];

   uart_led_top #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .reset(reset), .uart_rx(uart_rx), .btn1(btn1), .uart_tx(uart_tx), .leds(leds)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_head(input logic [7:0] d);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = d[i];
         repeat (CPB) @(negedge clk);
      end
   endtask

   task automatic send_stop(input logic s);
      uart_rx = s;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      rx_q.push_back(v.exp);
      send_head(v.data);
      chk($sformatf("rx_pre_stop_%h", v.data), {24'h0, leds}, {24'h0, cur_leds});
      send_stop(v.stop);
      cur_leds = rx_q.pop_front();
      chk($sformatf("rx_frame_%h", v.data), {24'h0, leds}, {24'h0, cur_leds});
      repeat (v.gap) @(negedge clk);
      chk($sformatf("rx_hold_%h", v.data), {24'h0, leds}, {24'h0, cur_leds});
   endtask

   task automatic check_tx_frame();
      logic b;
      int w = 0;
      while (uart_tx !== 1'b0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (uart_tx !== 1'b0) begin
         chk("tx_start_timeout", {31'h0, uart_tx}, 32'h0);
         tx_q.delete();
      end else begin
         for (int i = 0; i < 10; i++) begin
            b = tx_q.pop_front();
            @(negedge clk);
            chk($sformatf("tx_bit%0d_early", i), {31'h0, uart_tx}, {31'h0, b});
            repeat (6) @(negedge clk);
            chk($sformatf("tx_bit%0d_late", i), {31'h0, uart_tx}, {31'h0, b});
            @(negedge clk);
         end
         chk("tx_idle_after", {31'h0, uart_tx}, 32'h1);
      end
   endtask

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 8'hA5, 40};
      vecs[1] = '{8'h3C, 1'b1, 8'h3C, 0};
      vecs[2] = '{8'h01, 1'b1, 8'h01, 10};
      vecs[3] = '{8'hFF, 1'b0, 8'h01, 20};
      vecs[4] = '{8'h5A, 1'b1, 8'h5A, 10};
      vecs[5] = '{8'hC3, 1'b1, 8'hC3, 0};
      repeat (3) @(negedge clk);
      chk("reset_leds", {24'h0, leds}, 32'h0);
      chk("reset_tx", {31'h0, uart_tx}, 32'h1);
      reset = 1'b0;
      repeat (500) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || leds !== 8'h00) bad++;
      end
      chk("idle_500_bad_samples", bad, 0);
      for (int i = 0; i < 3; i++) run_vec(vecs[i]);
      uart_rx = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx = 1'b1;
      repeat (20) @(negedge clk);
      chk("rx_glitch", {24'h0, leds}, {24'h0, cur_leds});
      for (int i = 3; i < 5; i++) run_vec(vecs[i]);
      // A new byte lands on leds while the previous value is still being sent.
      fork
         run_vec(vecs[5]);
         begin
            repeat (40) @(negedge clk);
            btn1 = 1'b0;
            tx_byte = cur_leds;
            tx_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) tx_q.push_back(tx_byte[i]);
            tx_q.push_back(1'b1);
            check_tx_frame();
         end
         begin
            repeat (60) @(negedge clk);
            btn1 = 1'b1;
         end
      join
      chk("tx_byte_was_5a", {24'h0, tx_byte}, 32'h5A);
      repeat (20) @(negedge clk);
      btn1 = 1'b0;
      t = 0;
      while (uart_tx !== 1'b0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("tx2_started", {31'h0, uart_tx}, 32'h0);
      repeat (30) @(negedge clk);
      reset = 1'b1;
      btn1 = 1'b1;
      #1;
      chk("reset_mid_tx", {31'h0, uart_tx}, 32'h1);
      chk("reset_mid_leds", {24'h0, leds}, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || leds !== 8'h00) bad++;
      end
      chk("post_reset_idle_bad_samples", bad, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
